// File: rtl/afifo_rd_multi_monitor_pkg.sv
// Shared types and helpers for the async-FIFO read-side monitor.
// The entry struct is sized for the default configuration (4 channels, 8-bit data, 16-bit timestamp).
package afifo_tb_pkg;

  localparam int LOG_CH_W   = 2;
  localparam int LOG_DATA_W = 8;
  localparam int LOG_TS_W   = 16;

  typedef struct packed {
    logic [LOG_CH_W-1:0]   ch;
    logic [LOG_DATA_W-1:0] data;
    logic                  uf;
    logic [LOG_TS_W-1:0]   ts;
  } rd_log_entry_t;

  // Adds add to value and clamps the result at 2^width-1 (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] add,
                                          input int width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, value} + {1'b0, add};
    max = (33'd1 << width) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/afifo_rd_multi_monitor_log_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Head fields read as zero while empty so nothing undefined leaks out after reset.
module afifo_log_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (level_reg != '0);
  assign do_push = push & ((level_reg != FULL_LEVEL) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign out_valid = (level_reg != '0);
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
  assign level     = level_reg;

endmodule

// File: rtl/afifo_rd_multi_monitor.sv
// Read-side monitor for NUM_CH async-FIFO read ports: timestamps reads, flags underflows,
// merges events round-robin into one log FIFO and keeps saturating statistics.
module afifo_rd_multi_monitor
  import afifo_tb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                          rclk,
  input  logic                                          rrst,
  input  logic                                          en,
  input  logic                                          uf_only,
  input  logic [NUM_CH-1:0]                             rinc,
  input  logic [NUM_CH-1:0]                             rempty,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  rdata,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic                                          out_uf,
  output logic [TS_WIDTH-1:0]                           out_ts,
  output logic [NUM_CH*CNT_WIDTH-1:0]                   rd_count,
  output logic [CNT_WIDTH-1:0]                          uf_count,
  output logic [CNT_WIDTH-1:0]                          drop_count,
  output logic                                          drop_sticky,
  output logic [$clog2(DEPTH):0]                        log_level
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = CH_W + DATA_WIDTH + 1 + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts_reg;
  logic [NUM_CH-1:0]   rd_good;
  logic [NUM_CH-1:0]   rd_uf;
  logic [NUM_CH-1:0]   drop;
  logic [NUM_CH-1:0]   pend_valid;
  logic [ENTRY_W-1:0]  pend_entry [NUM_CH];
  logic [CH_W-1:0]     rr_ptr_reg;
  logic [CH_W-1:0]     grant_idx;
  logic                grant;
  logic                room;
  logic [ENTRY_W-1:0]  head_entry;
  int                  idx;

  always_ff @(posedge rclk) begin
    if (rrst) ts_reg <= '0;
    else      ts_reg <= ts_reg + TS_WIDTH'(1);
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                 ev;
      logic                 granted;
      logic                 valid_reg;
      logic [ENTRY_W-1:0]   entry_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;

      assign ev          = en & rinc[gi] & (~uf_only | rempty[gi]);
      assign rd_good[gi] = en & rinc[gi] & ~rempty[gi];
      assign rd_uf[gi]   = en & rinc[gi] & rempty[gi];
      assign granted     = grant & (grant_idx == CH_W'(gi));
      // A slot freed by this cycle's grant can take a new event on the same edge.
      assign drop[gi]    = ev & valid_reg & ~granted;

      always_ff @(posedge rclk) begin
        if (rrst) begin
          valid_reg <= 1'b0;
          entry_reg <= '0;
          cnt_reg   <= '0;
        end else begin
          if (ev && !drop[gi]) begin
            valid_reg <= 1'b1;
            entry_reg <= {CH_W'(gi),
                          rempty[gi] ? DATA_WIDTH'(0) : rdata[gi*DATA_WIDTH +: DATA_WIDTH],
                          rempty[gi], ts_reg};
          end else if (granted) begin
            valid_reg <= 1'b0;
          end
          if (rd_good[gi])
            cnt_reg <= CNT_WIDTH'(sat_inc(32'(cnt_reg), 32'd1, CNT_WIDTH));
        end
      end

      assign pend_valid[gi]                       = valid_reg;
      assign pend_entry[gi]                       = entry_reg;
      assign rd_count[gi*CNT_WIDTH +: CNT_WIDTH]  = cnt_reg;
    end
  endgenerate

  assign room = (log_level < LVL_W'(DEPTH)) | (out_valid & out_ready);

  // Scan from farthest to nearest offset so the slot closest to rr_ptr wins.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (room && pend_valid[idx]) begin
        grant     = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rr_ptr_reg  <= '0;
      uf_count    <= '0;
      drop_count  <= '0;
      drop_sticky <= 1'b0;
    end else begin
      if (grant)
        rr_ptr_reg <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      uf_count   <= CNT_WIDTH'(sat_inc(32'(uf_count), 32'($countones(rd_uf)), CNT_WIDTH));
      drop_count <= CNT_WIDTH'(sat_inc(32'(drop_count), 32'($countones(drop)), CNT_WIDTH));
      if (drop != '0) drop_sticky <= 1'b1;
    end
  end

  afifo_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_log (
    .clk       (rclk),
    .srst      (rrst),
    .push      (grant),
    .push_data (pend_entry[grant_idx]),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (head_entry),
    .level     (log_level)
  );

  assign {out_ch, out_data, out_uf, out_ts} = head_entry;

endmodule

// File: tb/tb_afifo_rd_multi_monitor.sv
// Directed bench for afifo_rd_multi_monitor with a scoreboard queue of expected log entries.
module tb_afifo_rd_multi_monitor;
  import afifo_tb_pkg::*;

  localparam int DW = 8, NCH = 4, DEPTH = 16, TSW = 16, CW = 16;

  logic           clk = 1'b0;
  logic           rrst, en, uf_only, out_ready;
  logic [NCH-1:0] rinc, rempty;
  logic [NCH*DW-1:0] rdata;
  logic           out_valid, out_uf, drop_sticky;
  logic [1:0]     out_ch;
  logic [DW-1:0]  out_data;
  logic [TSW-1:0] out_ts;
  logic [NCH*CW-1:0] rd_count;
  logic [CW-1:0]  uf_count, drop_count;
  logic [4:0]     log_level;

  int errors = 0;
  int checks = 0;
  rd_log_entry_t  q[$];
  logic [TSW-1:0] tb_ts;

  always #5 clk = ~clk;

  afifo_rd_multi_monitor #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(CW)
  ) dut (
    .rclk(clk), .rrst(rrst), .en(en), .uf_only(uf_only), .rinc(rinc), .rempty(rempty),
    .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_uf(out_uf), .out_ts(out_ts), .rd_count(rd_count),
    .uf_count(uf_count), .drop_count(drop_count), .drop_sticky(drop_sticky),
    .log_level(log_level)
  );

  // Reference timestamp: cleared by a reset edge, +1 on every other edge.
  always @(posedge clk) tb_ts <= (rrst === 1'b1) ? '0 : tb_ts + 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    rd_log_entry_t got;
    rd_log_entry_t exp;
    if (rrst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      got = {out_ch, out_data, out_uf, out_ts};
      check("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp = q.pop_front();
        check("log_entry", 64'(got), 64'(exp));
        $display("entry ch=%0d data=%h uf=%0d ts=%h", got.ch, got.data, got.uf, got.ts);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    rinc = '0;
    tick();
    rrst = 1'b0;
    q.delete();
  endtask

  task automatic set_data(input int c, input logic [7:0] d);
    rdata[c*DW +: DW] = d;
  endtask

  task automatic expect_ev(input int c, input logic [7:0] d, input logic uf);
    rd_log_entry_t e;
    e.ch   = 2'(c);
    e.data = uf ? 8'h00 : d;
    e.uf   = uf;
    e.ts   = tb_ts;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    check({tag, "_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_level"}, 64'(log_level), 64'd0);
    check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
    check({tag, "_uf_count"}, 64'(uf_count), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    check({tag, "_drop_sticky"}, 64'(drop_sticky), 64'd0);
    check({tag, "_head_ts"}, 64'(out_ts), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b0; en = 1'b1; uf_only = 1'b0; out_ready = 1'b1;
    rinc = '0; rempty = '0; rdata = '0;
    do_reset();
    check_cleared("reset");

    // 1: single good read on ch0 at ts=10
    while (tb_ts != 16'd10) tick();
    rinc = 4'b0001; set_data(0, 8'hA5); expect_ev(0, 8'hA5, 1'b0);
    tick();
    rinc = '0;
    wait_drain("t1", 20);
    check("t1_rd_count0", 64'(rd_count[0*CW +: CW]), 64'd1);

    // 2: all channels read on one edge, drained in channel order on consecutive cycles
    do_reset();
    rinc = 4'hF;
    for (int c = 0; c < NCH; c++) begin
      set_data(c, 8'(8'h11 * (c + 1)));
      expect_ev(c, 8'(8'h11 * (c + 1)), 1'b0);
    end
    tick();
    rinc = '0;
    for (int i = 0; i < NCH; i++) begin
      tick();
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_level_le1", 64'(log_level <= 5'd1), 64'd1);
    end
    wait_drain("t2", 10);
    check("t2_drop_count", 64'(drop_count), 64'd0);

    // 3: underflow-only logging on ch2
    do_reset();
    uf_only = 1'b1; rinc = 4'b0100; set_data(2, 8'h5A);
    repeat (3) tick();
    rempty = 4'b0100; expect_ev(2, 8'h5A, 1'b1);
    tick();
    rinc = '0; rempty = '0; uf_only = 1'b0;
    wait_drain("t3", 20);
    check("t3_rd_count2", 64'(rd_count[2*CW +: CW]), 64'd3);
    check("t3_uf_count", 64'(uf_count), 64'd1);

    // 4: log fills with the consumer stalled; pending holds one, two events drop
    do_reset();
    out_ready = 1'b0; rinc = 4'b0010;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_data(1, 8'(i + 1));
      if (i <= DEPTH) expect_ev(1, 8'(i + 1), 1'b0);
      tick();
    end
    rinc = '0;
    check("t4_level_full", 64'(log_level), 64'(DEPTH));
    check("t4_drop_count", 64'(drop_count), 64'd2);
    check("t4_drop_sticky", 64'(drop_sticky), 64'd1);
    repeat (3) tick();
    check("t4_level_hold", 64'(log_level), 64'(DEPTH));
    check("t4_drop_hold", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
    wait_drain("t4", 60);
    check("t4_rd_count1", 64'(rd_count[1*CW +: CW]), 64'(DEPTH + 3));

    // 5: timestamp wrap across reads at FFFE, FFFF, 0000
    while (tb_ts != 16'hFFFE) tick();
    rinc = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      set_data(3, 8'(8'hC0 + i));
      expect_ev(3, 8'(8'hC0 + i), 1'b0);
      tick();
    end
    rinc = '0;
    wait_drain("t5", 20);
    check("t5_drop_count", 64'(drop_count), 64'd2);

    // 6: reset while the log is part-drained
    out_ready = 1'b0; rinc = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      set_data(0, 8'(8'h70 + i));
      expect_ev(0, 8'(8'h70 + i), 1'b0);
      tick();
    end
    rinc = 4'b0010; rempty = 4'b0010; expect_ev(1, 8'h00, 1'b1);
    tick();
    rinc = '0; rempty = '0;
    repeat (3) tick();
    check("t6_level_full8", 64'(log_level), 64'd8);
    check("t6_uf_count", 64'(uf_count), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("t6_level_5", 64'(log_level), 64'd5);
    do_reset();
    check_cleared("t6_after_reset");
    check("t6_queue_left", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
